// File: rtl/sqrt_prenorm_if.sv
// Operand/result handshake bundle for sqrt_prenorm.
//   in_valid/in_ready/a          : operand channel (upstream -> block)
//   out_valid/out_ready          : result channel (block -> downstream)
//   d/shift/zero                 : result payload, valid while out_valid=1
// modport slave  : the normalizer side
// modport master : the producer/consumer side driving it
interface sqrt_prenorm_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic [3:0]  shift;
    logic        zero;

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, d, shift, zero
    );

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, d, shift, zero
    );
endinterface

// File: rtl/sqrt_prenorm.sv
// Operand pre-normalizer for the Newton-Raphson square-root core.
// Shifts a 32-bit unsigned operand left by whole bit-pairs until
// d[31:30] != 0, so that sqrt(a) = sqrt(d) * 2^(16 - shift).
// Ports:
//   clk   : rising-edge clock
//   clrn  : asynchronous active-low reset
//   bus   : sqrt_prenorm_if.slave (in_valid/in_ready/a, out_valid/out_ready,
//           d/shift/zero)
// Parameter PAIRS_PER_CYCLE (1 or 2) sets how many bit-pairs one SHIFT
// cycle may consume.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for an operand (in_ready=1)
// SHIFT | normalizing; one step of up to PAIRS_PER_CYCLE pairs per cycle
// DONE  | result held on d/shift/zero with out_valid=1 until out_ready
module sqrt_prenorm #(
    parameter int PAIRS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          clrn,
    sqrt_prenorm_if.slave bus
);

    if (PAIRS_PER_CYCLE != 1 && PAIRS_PER_CYCLE != 2) begin : g_param_check
        $error("sqrt_prenorm: PAIRS_PER_CYCLE must be 1 or 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d;
    logic        accept;
    logic        two_pairs;

    assign accept = bus.in_valid && (state_q == IDLE);

    // A double step is only taken when both leading pairs are zero, so the
    // shift never pushes a set bit out of bit 31 and count tops out at 15.
    assign two_pairs = (PAIRS_PER_CYCLE == 2) && (d_q[31:28] == 4'b0000);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            d_q     <= 32'd0;
            cnt_q   <= 4'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                // Operand is only looked at on acceptance, so an X on `a`
                // while in_valid=0 never reaches the registers.
                if (accept) begin
                    d_d     = bus.a;
                    cnt_d   = 4'd0;
                    zero_d  = (bus.a == 32'd0);
                    state_d = (bus.a == 32'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (d_q[31:30] != 2'b00) begin
                    state_d = DONE;
                end else if (two_pairs) begin
                    d_d   = {d_q[27:0], 4'b0000};
                    cnt_d = cnt_q + 4'd2;
                end else begin
                    d_d   = {d_q[29:0], 2'b00};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.d         = d_q;
    assign bus.shift     = cnt_q;
    assign bus.zero      = zero_q;

endmodule
